// File: rtl/grf_scoreboard.sv
// ---------------------------------------------------------------------------
// grf_scoreboard
//
// General-purpose register file for the pipelined MIPS core.
// Provides NRD combinational read ports and an optional same-cycle
// write-to-read bypass. Register 0 is hardwired to zero. Each register also
// has a 2-bit pending-write counter, so decode can detect RAW hazards against
// writes that have been issued but not yet retired.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  address width; depth = 2**ADDR_W
//   NRD     number of read ports (1..4)
//   BYPASS  1 = write-back data forwarded to same-cycle reads
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      synchronous active-high; clears registers and counters
//   ra         read addresses, port k = ra[k*ADDR_W +: ADDR_W]
//   rdata      read data, port k = rdata[k*DATA_W +: DATA_W]
//   rbusy      port k's register has an outstanding pending write
//   iss_valid  decode issues an instruction writing iss_addr
//   iss_addr   destination register of the issued instruction
//   iss_full   pending counter of iss_addr saturated; issue refused
//   we/wa/wd   write-back retire strobe, address and data
//   wpc        PC of the retiring instruction (trace only)
// ---------------------------------------------------------------------------
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*DATA_W-1:0]   rdata,
  output logic [NRD-1:0]          rbusy,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic                    iss_full,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic [31:0]             wpc
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [1:0]        r_cnt  [DEPTH];

  logic              w_wr_en;
  logic              w_iss_full;
  logic              w_iss_take;
  logic [DEPTH-1:0]  w_inc;
  logic [DEPTH-1:0]  w_dec;
  logic [ADDR_W-1:0] w_ra_k;
  logic              w_hit_k;
  logic [NRD*DATA_W-1:0] w_rdata;
  logic [NRD-1:0]        w_rbusy;

  // wpc only feeds the retire trace, which the simulation environment emits;
  // it carries no state in this datapath.
  logic w_unused_wpc;
  assign w_unused_wpc = ^wpc;

  // Writes to register 0 are discarded entirely.
  assign w_wr_en = we && (wa != {ADDR_W{1'b0}});

  // Issue is refused only when the destination counter is saturated and no
  // retire to the same register frees a slot in this cycle.
  assign w_iss_full = iss_valid && (iss_addr != {ADDR_W{1'b0}}) &&
                      (r_cnt[iss_addr] == 2'd3) && !(we && (wa == iss_addr));
  assign w_iss_take = iss_valid && (iss_addr != {ADDR_W{1'b0}}) && !w_iss_full;

  // Per-register increment/decrement requests; register 0 is never counted.
  always_comb begin
    w_inc = {DEPTH{1'b0}};
    w_dec = {DEPTH{1'b0}};
    for (int r = 1; r < DEPTH; r++) begin
      w_inc[r] = w_iss_take && (iss_addr == ADDR_W'(r));
      // A retire against an empty counter is an untracked write: no underflow.
      w_dec[r] = we && (wa == ADDR_W'(r)) && (r_cnt[r] != 2'd0);
    end
  end

  // Combinational read ports with optional write-back forwarding.
  always_comb begin
    w_rdata = {NRD*DATA_W{1'b0}};
    w_rbusy = {NRD{1'b0}};
    w_ra_k  = {ADDR_W{1'b0}};
    w_hit_k = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      w_ra_k  = ra[k*ADDR_W +: ADDR_W];
      w_hit_k = (BYPASS != 0) && we && (wa == w_ra_k);
      if (w_ra_k == {ADDR_W{1'b0}}) begin
        w_rdata[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        w_rbusy[k]                  = 1'b0;
      end else if (w_hit_k) begin
        // The forwarded retire satisfies one pending write, so the port is
        // only still busy if more than one was outstanding.
        w_rdata[k*DATA_W +: DATA_W] = wd;
        w_rbusy[k]                  = (r_cnt[w_ra_k] != 2'd0) &&
                                      (r_cnt[w_ra_k] != 2'd1);
      end else begin
        w_rdata[k*DATA_W +: DATA_W] = r_regs[w_ra_k];
        w_rbusy[k]                  = (r_cnt[w_ra_k] != 2'd0);
      end
    end
  end

  assign rdata    = w_rdata;
  assign rbusy    = w_rbusy;
  assign iss_full = w_iss_full;

  // Register storage and pending counters; reset wins over write and issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        r_regs[r] <= {DATA_W{1'b0}};
        r_cnt[r]  <= 2'd0;
      end
    end else begin
      if (w_wr_en) begin
        r_regs[wa] <= wd;
      end else begin
        r_regs[wa] <= r_regs[wa];
      end
      for (int r = 0; r < DEPTH; r++) begin
        if (w_inc[r] && !w_dec[r]) begin
          r_cnt[r] <= r_cnt[r] + 2'd1;
        end else if (!w_inc[r] && w_dec[r]) begin
          r_cnt[r] <= r_cnt[r] - 2'd1;
        end else begin
          r_cnt[r] <= r_cnt[r];
        end
      end
    end
  end

endmodule
